ysyx_22041752_icache_sram_resp: RTL and testbench
=================================================

Name: ysyx_22041752_icache_sram_resp

Overview:
- Responder end of the I-cache refill SRAM-style interface (sram_req/sram_ready/sram_addr/sram_rdata/sram_valid).
- Accepts one 64-bit refill read at a time from the I-cache miss FSM and converts it to a single-beat AXI4 read (AR/R channels).
- Returns the data to the cache with a one-cycle sram_valid pulse.
- Sits between the I-cache compare stage and the system AXI crossbar.

Parameters:
- ADDR_WD, 32, address width (matches SRAM_ADDR_WD).
- DATA_WD, 64, data width (matches SRAM_DATA_WD).
- AXI_ID, 0, constant arid driven on AR.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- sram_req  in  1  read request; initiator deasserts it combinationally in the cycle sram_ready is high.
- sram_ready  out  1  one-cycle accept pulse.
- sram_addr  in  ADDR_WD  request address, 8-byte aligned.
- sram_rdata  out  DATA_WD  read data, meaningful when sram_valid=1.
- sram_valid  out  1  one-cycle data-return pulse.
- arvalid  out  1  AXI AR valid.
- arready  in  1  AXI AR ready.
- araddr  out  ADDR_WD  AXI AR address.
- arid  out  4  AXI AR id = AXI_ID.
- arlen  out  8  constant 0 (single beat).
- arsize  out  3  constant 3'b011 (8 bytes).
- arburst  out  2  constant 2'b01 (INCR).
- rvalid  in  1  AXI R valid.
- rready  out  1  AXI R ready.
- rdata  in  DATA_WD  AXI R data.
- rresp  in  2  AXI R response.
- rlast  in  1  AXI R last (expected 1).

Behaviour:
- One clock (clk); reset synchronous, active-high. All state and output registers clear on reset. The FSM returns to IDLE; sram_ready, sram_valid, arvalid and rready are 0; sram_rdata and araddr are 0.
- FSM states: IDLE, ACCEPT, AR, R, RESP.
- IDLE: if sram_req=1, latch sram_addr into addr_r and go to ACCEPT.
- ACCEPT: sram_ready=1 for exactly this cycle; go to AR. sram_req is ignored here (the initiator drops it).
- AR: arvalid=1, araddr=addr_r. Stay until arready=1 is sampled, then go to R. arvalid and araddr are held stable while waiting.
- R: rready=1. On rvalid=1, register rdata into data_r and go to RESP. rlast is not checked.
- RESP: sram_valid=1 for one cycle with sram_rdata=data_r; go to IDLE.
- sram_rdata holds data_r after RESP until the next capture.
- Minimum latency: req sampled at cycle 0 → ready at cycle 1 → arvalid at cycle 2 → earliest R capture at cycle 3 → sram_valid at cycle 4.
- A new request can be accepted the cycle after RESP (back-to-back lower/upper half refills).
- Exactly one outstanding transaction. sram_req is ignored in every state except IDLE; the initiator holds req and is served later.
- The initiator's flush/drop states still consume the response, so every accepted request completes on AXI and pulses sram_valid. There is no abort path.
- Reset mid-transaction: abandon immediately, return to IDLE. The system resets AXI slaves simultaneously, so no stray R beat is expected.
- rresp≠OKAY: data is still returned as-is; see optional feature.
- Unaligned sram_addr (bits [2:0]≠0) is forwarded unchanged; alignment is the initiator's responsibility.

Optional Feature:
- Macro: YSYX_22041752_ICACHE_RESP_ERR_EN.
- Defined: adds output port resp_err (1 bit), sticky. It sets in the cycle an R beat with rresp≠2'b00 is captured and clears only on reset. The returned data in that case is forced to 64'h0 (decodes to an illegal instruction, trapped downstream).
- Undefined: no resp_err port; rresp is unused (lint waiver) and data is passed through unmodified.

Decomposition:
- Shared header (ysyx_22041752_mycpu.vh) gets FSM state encodings (IDLE=0, ACCEPT=1, AR=2, R=3, RESP=4, 3-bit) and the AXI constants (AXI_SIZE_8B=3'b011, AXI_BURST_INCR=2'b01, AXI_RESP_OKAY=2'b00).
- SRAM_ADDR_WD and SRAM_DATA_WD are reused from the existing header.
- No sub-module; a single flat FSM plus datapath registers.

Test Plan:
- Single read, zero wait: req with addr=0x8000_0010, arready=1 immediately, rvalid the cycle after rready with rdata=0x1122_3344_5566_7788 → ready at cycle 1; araddr=0x8000_0010, arlen=0, arsize=3 at cycle 2; sram_valid pulse with rdata=0x1122334455667788 at cycle 4.
- AR backpressure: arready low for 5 cycles → arvalid and araddr stable throughout, no second ready pulse, sram_valid exactly once after the R beat.
- Back-to-back refill: addr 0x8000_0020 then 0x8000_0028, each with R delay of 3 cycles → two ready pulses, two sram_valid pulses, data returned in order. The second request is accepted the cycle after the first RESP.
- Req held while busy: hold sram_req=1 through an outstanding transaction → no ready until IDLE; exactly one extra accept follows.
- Reset in R state: assert reset while rready=1 → the next cycle shows FSM in IDLE, all valid/ready outputs 0, sram_rdata=0.
- Error (macro on): rresp=2'b10 with rdata=0xDEAD → sram_rdata=0, resp_err=1 and stays 1 across later OKAY reads until reset.

Source files
------------

// File: rtl/ysyx_22041752_icache_sram_resp_pkg.sv
// Shared constants and FSM encoding for the I-cache refill responder.
// Optional feature macro: YSYX_22041752_ICACHE_RESP_ERR_EN (see top module).
package ysyx_22041752_icache_sram_resp_pkg;

    localparam int SRAM_ADDR_WD = 32;
    localparam int SRAM_DATA_WD = 64;

    localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCEPT = 3'd1,
        AR     = 3'd2,
        R      = 3'd3,
        RESP   = 3'd4
    } state_e;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != AXI_RESP_OKAY;
    endfunction

endpackage

// File: rtl/ysyx_22041752_icache_sram_resp_if.sv
// Bundles the cache-side SRAM handshake and the AXI AR/R read channels.
// slave: the responder block; master: the cache + AXI fabric around it.
interface ysyx_22041752_icache_sram_resp_if
    import ysyx_22041752_icache_sram_resp_pkg::*;
#(
    parameter int ADDR_WD = SRAM_ADDR_WD,
    parameter int DATA_WD = SRAM_DATA_WD
);
    logic               sram_req;
    logic               sram_ready;
    logic [ADDR_WD-1:0] sram_addr;
    logic [DATA_WD-1:0] sram_rdata;
    logic               sram_valid;

    logic               arvalid;
    logic               arready;
    logic [ADDR_WD-1:0] araddr;
    logic [3:0]         arid;
    logic [7:0]         arlen;
    logic [2:0]         arsize;
    logic [1:0]         arburst;

    logic               rvalid;
    logic               rready;
    logic [DATA_WD-1:0] rdata;
    logic [1:0]         rresp;
    logic               rlast;

    modport slave (
        input  sram_req, sram_addr,
        output sram_ready, sram_rdata, sram_valid,
        output arvalid, araddr, arid, arlen, arsize, arburst,
        input  arready,
        input  rvalid, rdata, rresp, rlast,
        output rready
    );

    modport master (
        output sram_req, sram_addr,
        input  sram_ready, sram_rdata, sram_valid,
        input  arvalid, araddr, arid, arlen, arsize, arburst,
        output arready,
        output rvalid, rdata, rresp, rlast,
        input  rready
    );
endinterface

// File: rtl/ysyx_22041752_icache_sram_resp.sv
// I-cache refill responder: one SRAM-style read in, one single-beat AXI read out.
// Define YSYX_22041752_ICACHE_RESP_ERR_EN to add the sticky resp_err output.
module ysyx_22041752_icache_sram_resp
    import ysyx_22041752_icache_sram_resp_pkg::*;
#(
    parameter int ADDR_WD = SRAM_ADDR_WD,
    parameter int DATA_WD = SRAM_DATA_WD,
    parameter int AXI_ID  = 0
)(
    input  logic clk,
    input  logic reset,
    ysyx_22041752_icache_sram_resp_if.slave bus
`ifdef YSYX_22041752_ICACHE_RESP_ERR_EN
    ,
    output logic resp_err
`endif
);

    state_e             r_state;
    state_e             w_state_next;
    logic [ADDR_WD-1:0] r_addr;
    logic [DATA_WD-1:0] r_data;
    logic [DATA_WD-1:0] w_cap_data;
    logic               w_err_beat;
    logic               w_sram_ready;
    logic               w_sram_valid;
    logic               w_arvalid;
    logic               w_rready;
    logic               w_capture;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_sram_ready = 1'b0;
        w_sram_valid = 1'b0;
        w_arvalid    = 1'b0;
        w_rready     = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.sram_req) w_state_next = ACCEPT;
            end
            ACCEPT: begin
                w_sram_ready = 1'b1;
                w_state_next = AR;
            end
            AR: begin
                w_arvalid = 1'b1;
                if (bus.arready) w_state_next = R;
            end
            R: begin
                w_rready = 1'b1;
                if (bus.rvalid) w_state_next = RESP;
            end
            RESP: begin
                w_sram_valid = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign w_capture = (r_state == R) && bus.rvalid;

`ifdef YSYX_22041752_ICACHE_RESP_ERR_EN
    logic r_resp_err;

    // An errored beat returns all-zero, which decodes as an illegal instruction.
    assign w_err_beat = resp_is_err(bus.rresp);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_resp_err <= 1'b0;
        end else if (w_capture && w_err_beat) begin
            r_resp_err <= 1'b1;
        end
    end

    assign resp_err = r_resp_err;
`else
    assign w_err_beat = 1'b0;
`endif

    generate
        for (genvar gi = 0; gi < DATA_WD / 8; gi++) begin : g_lane
            assign w_cap_data[gi*8 +: 8] = w_err_beat ? 8'h00 : bus.rdata[gi*8 +: 8];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr <= '0;
            r_data <= '0;
        end else begin
            if (r_state == IDLE && bus.sram_req) r_addr <= bus.sram_addr;
            if (w_capture)                       r_data <= w_cap_data;
        end
    end

    assign bus.sram_ready = w_sram_ready;
    assign bus.sram_valid = w_sram_valid;
    assign bus.sram_rdata = r_data;
    assign bus.arvalid    = w_arvalid;
    assign bus.araddr     = r_addr;
    assign bus.arid       = 4'(AXI_ID);
    assign bus.arlen      = 8'd0;
    assign bus.arsize     = AXI_SIZE_8B;
    assign bus.arburst    = AXI_BURST_INCR;
    assign bus.rready     = w_rready;

endmodule

// File: tb/tb_ysyx_22041752_icache_sram_resp.sv
// Directed bench for the I-cache refill responder with a data scoreboard.
module tb_ysyx_22041752_icache_sram_resp;
    import ysyx_22041752_icache_sram_resp_pkg::*;

    logic clk;
    logic reset;
    int   n_total = 0;
    int   n_pass  = 0;
    int   n_fail  = 0;
    int   n_ready = 0;
    int   n_valid = 0;
    int   cyc     = 0;
    int   last_ready_cyc = 0;
    int   last_valid_cyc = 0;
    logic [63:0] sb_q[$];

    ysyx_22041752_icache_sram_resp_if #(.ADDR_WD(32), .DATA_WD(64)) bus ();

`ifdef YSYX_22041752_ICACHE_RESP_ERR_EN
    logic resp_err;
    ysyx_22041752_icache_sram_resp #(.ADDR_WD(32), .DATA_WD(64), .AXI_ID(0)) dut (
        .clk(clk), .reset(reset), .bus(bus), .resp_err(resp_err));
`else
    ysyx_22041752_icache_sram_resp #(.ADDR_WD(32), .DATA_WD(64), .AXI_ID(0)) dut (
        .clk(clk), .reset(reset), .bus(bus));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model_data(input logic [63:0] data, input logic [1:0] resp);
`ifdef YSYX_22041752_ICACHE_RESP_ERR_EN
        return (resp != 2'b00) ? 64'h0 : data;
`else
        return data;
`endif
    endfunction

    // Response monitor: counts pulses and checks returned data against the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.sram_ready === 1'b1) begin
                n_ready++;
                last_ready_cyc = cyc;
            end
            if (bus.sram_valid === 1'b1) begin
                n_valid++;
                last_valid_cyc = cyc;
                chk("sb_has_entry", 64'(sb_q.size() != 0), 64'd1);
                if (sb_q.size() != 0) chk("sb_data", bus.sram_rdata, sb_q.pop_front());
                $display("resp cyc=%0d data=0x%016h", cyc, bus.sram_rdata);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [63:0] data, input logic [1:0] resp,
                           input int ar_wait, input int r_wait, input bit hold);
        int n;
        logic [63:0] exp;
        exp = model_data(data, resp);
        sb_q.push_back(exp);
        $display("req addr=0x%08h data=0x%016h resp=%0d ar_wait=%0d r_wait=%0d hold=%0d",
                 addr, data, resp, ar_wait, r_wait, hold);
        bus.sram_req  = 1'b1;
        bus.sram_addr = addr;
        bus.arready   = 1'b0;
        bus.rvalid    = 1'b0;
        n = 0;
        do begin
            step();
            n++;
        end while (bus.sram_ready !== 1'b1 && n < 20);
        chk("accept_latency", 64'(n), 64'd1);
        if (!hold) bus.sram_req = 1'b0;
        step();
        chk("ready_one_cycle", 64'(bus.sram_ready), 64'd0);
        for (int i = 0; i < ar_wait; i++) begin
            chk("ar_hold_valid", 64'(bus.arvalid), 64'd1);
            chk("ar_hold_addr", 64'(bus.araddr), 64'(addr));
            chk("ar_hold_no_ready", 64'(bus.sram_ready), 64'd0);
            step();
        end
        chk("arvalid", 64'(bus.arvalid), 64'd1);
        chk("araddr", 64'(bus.araddr), 64'(addr));
        chk("arlen", 64'(bus.arlen), 64'd0);
        chk("arsize", 64'(bus.arsize), 64'd3);
        chk("arburst", 64'(bus.arburst), 64'd1);
        chk("arid", 64'(bus.arid), 64'd0);
        bus.arready = 1'b1;
        step();
        bus.arready = 1'b0;
        chk("arvalid_drop", 64'(bus.arvalid), 64'd0);
        for (int i = 0; i < r_wait; i++) begin
            chk("rready_wait", 64'(bus.rready), 64'd1);
            step();
        end
        chk("rready", 64'(bus.rready), 64'd1);
        bus.rvalid = 1'b1;
        bus.rdata  = data;
        bus.rresp  = resp;
        bus.rlast  = 1'b1;
        step();
        bus.rvalid = 1'b0;
        bus.rdata  = {$urandom, $urandom};
        bus.rresp  = 2'b00;
        chk("sram_valid", 64'(bus.sram_valid), 64'd1);
        chk("rready_drop", 64'(bus.rready), 64'd0);
        step();
        chk("sram_valid_pulse", 64'(bus.sram_valid), 64'd0);
        chk("rdata_hold", bus.sram_rdata, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, v0, v1;
        reset         = 1'b1;
        bus.sram_req  = 1'b0;
        bus.sram_addr = '0;
        bus.arready   = 1'b0;
        bus.rvalid    = 1'b0;
        bus.rdata     = '0;
        bus.rresp     = 2'b00;
        bus.rlast     = 1'b0;
        repeat (3) step();
        reset = 1'b0;

        chk("rst_state", 64'(dut.r_state), 64'(IDLE));
        chk("rst_ready", 64'(bus.sram_ready), 64'd0);
        chk("rst_valid", 64'(bus.sram_valid), 64'd0);
        chk("rst_arvalid", 64'(bus.arvalid), 64'd0);
        chk("rst_rready", 64'(bus.rready), 64'd0);
        chk("rst_rdata", bus.sram_rdata, 64'd0);
        chk("rst_araddr", 64'(bus.araddr), 64'd0);

        // Single zero-wait read: ready at +1, sram_valid at +4.
        r0 = n_ready; v0 = n_valid;
        do_read(32'h8000_0010, 64'h1122_3344_5566_7788, 2'b00, 0, 0, 1'b0);
        chk("single_ready_cnt", 64'(n_ready - r0), 64'd1);
        chk("single_valid_cnt", 64'(n_valid - v0), 64'd1);
        chk("single_latency", 64'(last_valid_cyc - last_ready_cyc), 64'd3);

        // AR backpressure for 5 cycles.
        r0 = n_ready; v0 = n_valid;
        do_read(32'h8000_1000, 64'hCAFE_F00D_0123_4567, 2'b00, 5, 0, 1'b0);
        chk("bp_ready_cnt", 64'(n_ready - r0), 64'd1);
        chk("bp_valid_cnt", 64'(n_valid - v0), 64'd1);

        // Back-to-back halves; req held high through the first transaction.
        r0 = n_ready;
        do_read(32'h8000_0020, 64'hAAAA_0000_BBBB_1111, 2'b00, 0, 3, 1'b1);
        chk("held_ready_cnt", 64'(n_ready - r0), 64'd1);
        v1 = last_valid_cyc;
        do_read(32'h8000_0028, 64'hCCCC_2222_DDDD_3333, 2'b00, 0, 3, 1'b0);
        chk("b2b_ready_cnt", 64'(n_ready - r0), 64'd2);
        chk("b2b_accept_gap", 64'(last_ready_cyc - v1), 64'd2);

        // Unaligned address forwarded unchanged.
        do_read(32'h8000_0013, 64'h0F0E_0D0C_0B0A_0908, 2'b00, 1, 1, 1'b0);

        // Reset while in R.
        bus.sram_req  = 1'b1;
        bus.sram_addr = 32'h8000_0040;
        step();
        bus.sram_req = 1'b0;
        step();
        bus.arready = 1'b1;
        step();
        bus.arready = 1'b0;
        chk("pre_rst_rready", 64'(bus.rready), 64'd1);
        reset = 1'b1;
        step();
        $display("reset asserted in R state");
        chk("midrst_state", 64'(dut.r_state), 64'(IDLE));
        chk("midrst_ready", 64'(bus.sram_ready), 64'd0);
        chk("midrst_valid", 64'(bus.sram_valid), 64'd0);
        chk("midrst_arvalid", 64'(bus.arvalid), 64'd0);
        chk("midrst_rready", 64'(bus.rready), 64'd0);
        chk("midrst_rdata", bus.sram_rdata, 64'd0);
        chk("midrst_araddr", 64'(bus.araddr), 64'd0);
        reset = 1'b0;
        step();

`ifdef YSYX_22041752_ICACHE_RESP_ERR_EN
        chk("err_init", 64'(resp_err), 64'd0);
        do_read(32'h8000_0100, 64'h0000_0000_0000_DEAD, 2'b10, 0, 0, 1'b0);
        chk("err_set", 64'(resp_err), 64'd1);
        do_read(32'h8000_0108, 64'h5555_6666_7777_8888, 2'b00, 0, 1, 1'b0);
        chk("err_sticky", 64'(resp_err), 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("err_clear", 64'(resp_err), 64'd0);
`else
        do_read(32'h8000_0100, 64'h0000_0000_0000_DEAD, 2'b10, 0, 0, 1'b0);
`endif

        step();
        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
